multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore control FSM sequencing a multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut regs).
//  Decodes the latched IR opcode/funct, steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and enable.
//  Stalls on a memory ready handshake, counts retired instructions and traps on illegal opcodes or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready_i in a memory state before trapping to ERR
//  CNT_W        32  width of retire counter
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  instr_op_i     in   6      IR[31:26], valid from DECODE onward
//  instr_fun_i    in   6      IR[5:0]
//  zero_i         in   1      ALU zero flag (BRANCH state)
//  mem_ready_i    in   1      memory completes access this cycle
//  pc_write_o     out  1      unconditional PC load
//  pc_write_cond_o out 1      PC load if branch condition true
//  branch_ne_o    out  1      1: condition is !zero (bne); 0: zero (beq)
//  pc_source_o    out  2      0 ALU, 1 ALUOut, 2 jump target, 3 rs (jr)
//  i_or_d_o       out  1      memory addr: 0 PC, 1 ALUOut
//  mem_read_o     out  1      memory read request
//  mem_write_o    out  1      memory write request
//  ir_write_o     out  1      load IR
//  reg_write_o    out  1      register file write
//  reg_dst_o      out  2      0 rt, 1 rd, 2 r31
//  mem_to_reg_o   out  2      0 ALUOut, 1 MDR, 2 PC (link)
//  alu_src_a_o    out  1      0 PC, 1 A
//  alu_src_b_o    out  2      0 B, 1 const 4, 2 signext imm, 3 signext imm<<2
//  alu_op_o       out  3      000 add, 001 sub, 010 funct, 011 slt
//  retire_o       out  1      1-cycle pulse, last cycle of each instruction
//  retire_cnt_o   out  CNT_W  retired-instruction count
//  err_o          out  1      sticky: in ERR state
// BEHAVIOUR
//  Reset: state=IDLE, retire_cnt=0, timeout cnt=0; all outputs 0 in IDLE (no memory access during/after reset).
//  Outputs are pure functions of state (Moore), except pc_write_cond_o/branch_ne_o use latched op in BRANCH.
//  IDLE -> FETCH unconditionally next cycle.
//  FETCH: mem_read, i_or_d=0, ir_write, alu_src_a=0, alu_src_b=1, alu_op=add; pc_write, ir_write asserted only in the
//   cycle mem_ready_i=1, then -> DECODE; else stay. Multi-wait fetch never double-increments PC.
//  DECODE: alu_src_a=0, alu_src_b=3, add (branch target). Next by op:
//   0x00 funct 0x08 -> JR; 0x00 other -> EXEC; 0x23/0x2B -> MEMADR; 0x04/0x05 -> BRANCH;
//   0x08/0x0A -> IMMEX; 0x02 -> JUMP; 0x03 -> JAL; anything else -> ERR.
//  EXEC: src_a=1, src_b=0, alu_op=funct -> RWB. RWB: reg_write, reg_dst=1, mem_to_reg=0, retire -> FETCH.
//  IMMEX: src_a=1, src_b=2, alu_op add(0x08)/slt(0x0A) -> IWB. IWB: reg_write, reg_dst=0, mem_to_reg=0, retire -> FETCH.
//  MEMADR: src_a=1, src_b=2, add -> MEMRD (lw) or MEMWR (sw).
//  MEMRD: mem_read, i_or_d=1; hold until mem_ready_i -> MEMWB. MEMWB: reg_write, reg_dst=0, mem_to_reg=1, retire -> FETCH.
//  MEMWR: mem_write, i_or_d=1; hold until mem_ready_i; that cycle retire -> FETCH.
//  BRANCH: src_a=1, src_b=0, sub, pc_write_cond, pc_source=1, branch_ne=(op==0x05), retire -> FETCH.
//  JUMP: pc_write, pc_source=2, retire -> FETCH. JR: pc_write, pc_source=3, retire -> FETCH.
//  JAL: pc_write, pc_source=2, reg_write, reg_dst=2, mem_to_reg=2 (PC already +4), retire -> FETCH.
//  Timeout: counter clears on entering FETCH/MEMRD/MEMWR and on mem_ready_i; increments each waiting cycle;
//   if it reaches MEM_TIMEOUT with mem_ready_i=0 -> ERR. ERR: all outputs 0, err_o=1, exits only by reset.
//  retire_cnt increments by 1 per retire_o pulse, wraps modulo 2^CNT_W.
//  mem_read_o and mem_write_o never both 1; reg_write_o and pc_write_o only both 1 in JAL.
//  Async reset mid-instruction: immediate return to IDLE, no partial writes after rst_i falls.
// TESTING
//  Reset release, mem_ready_i=1 always, add (op 0, fun 0x20) -> IDLE,FETCH,DECODE,EXEC,RWB; retire on cycle 5; cnt=1.
//  lw with mem_ready_i low 3 cycles in MEMRD -> stays MEMRD 4 cycles, mem_read held, then MEMWB reg_write/mem_to_reg=1.
//  beq zero_i=1 then bne zero_i=1 -> pc_write_cond=1 both, branch_ne_o 0 then 1; 3 cycles each.
//  jal -> DECODE then JAL: pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2; jr (fun 0x08) -> pc_source=3.
//  Opcode 0x3F -> ERR after DECODE, err_o=1, outputs 0 until rst_i; mem_ready_i=0 for 15 cycles in FETCH -> ERR.
//  rst_i pulsed mid-MEMWR -> outputs 0 same cycle, retire_cnt=0, restart at IDLE; CNT_W=4, 16 retires -> cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: decoded-instruction inputs and datapath control bundle for the multi-cycle MIPS controller
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] instr_op;
  logic [5:0] instr_fun;
  logic zero;
  logic mem_ready;
  logic pc_write;
  logic pc_write_cond;
  logic branch_ne;
  logic [1:0] pc_source;
  logic i_or_d;
  logic mem_read;
  logic mem_write;
  logic ir_write;
  logic reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic retire;
  logic [CNT_W-1:0] retire_cnt;
  logic err;
  modport master (
    input instr_op, instr_fun, zero, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write, ir_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, retire_cnt, err
  );
  modport slave (
    output instr_op, instr_fun, zero, mem_ready,
    input pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write, ir_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, retire_cnt, err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing a multi-cycle MIPS datapath with memory stall, retire count and trap
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, RWB, IMMEX, IWB, MEMADR,
    MEMRD, MEMWB, MEMWR, BRANCH, JUMP, JR, JAL, ERR
  } state_t;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic [5:0] op;
  logic [CNT_W-1:0] cnt;
  logic waiting;
  assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !bus.mem_ready;
  assign bus.retire_cnt = cnt;
  assign bus.err = state == ERR;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      op <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      tcnt <= waiting ? tcnt + 1'b1 : '0;
      if (state == DECODE) op <= bus.instr_op;
      if (bus.retire) cnt <= cnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne = 1'b0;
    bus.pc_source = 2'd0;
    bus.i_or_d = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'd0;
    bus.alu_op = 3'b000;
    bus.retire = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.pc_write = bus.mem_ready;
        bus.ir_write = bus.mem_ready;
        state_n = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'd3;
        case (bus.instr_op)
          6'h00: state_n = bus.instr_fun == 6'h08 ? JR : EXEC;
          6'h23, 6'h2B: state_n = MEMADR;
          6'h04, 6'h05: state_n = BRANCH;
          6'h08, 6'h0A: state_n = IMMEX;
          6'h02: state_n = JUMP;
          6'h03: state_n = JAL;
          default: state_n = ERR;
        endcase
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = 3'b010;
        state_n = RWB;
      end
      RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = 2'd1;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        bus.alu_op = op == 6'h0A ? 3'b011 : 3'b000;
        state_n = IWB;
      end
      IWB: begin
        bus.reg_write = 1'b1;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        state_n = op == 6'h23 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d = 1'b1;
        state_n = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write = 1'b1;
        bus.mem_to_reg = 2'd1;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d = 1'b1;
        bus.retire = bus.mem_ready;
        state_n = bus.mem_ready ? FETCH : MEMWR;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = 3'b001;
        bus.pc_write_cond = 1'b1;
        bus.pc_source = 2'd1;
        bus.branch_ne = op == 6'h05;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      JUMP, JR: begin
        bus.pc_write = 1'b1;
        bus.pc_source = state == JR ? 2'd3 : 2'd2;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      JAL: begin
        bus.pc_write = 1'b1;
        bus.pc_source = 2'd2;
        bus.reg_write = 1'b1;
        bus.reg_dst = 2'd2;
        bus.mem_to_reg = 2'd2;
        bus.retire = 1'b1;
        state_n = FETCH;
      end
      default: state_n = ERR;
    endcase
    // a stalled access that has already waited MEM_TIMEOUT-1 cycles traps on this one
    if (waiting && tcnt == TW'(MEM_TIMEOUT - 1)) state_n = ERR;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked cycle by cycle against an instruction-level expectation table
module tb_multicycle_ctrl;
  localparam int CW = 4;
  typedef struct packed {
    logic pcw, pcc, bne;
    logic [1:0] psrc;
    logic iod, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r;
    logic asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic ret;
  } ctl_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit dead = 1'b0;
  ctl_t obs;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.retire};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input ctl_t e, input logic rdy, input logic e_err);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.zero = 1'($urandom);
    #1;
    check(tag, 64'(obs), 64'(e));
    check({tag, "_err"}, 64'(bus.err), 64'(e_err));
    check({tag, "_cnt"}, 64'(bus.retire_cnt), 64'(exp_cnt));
    if (e.ret) exp_cnt++;
  endtask
  task automatic trapped();
    for (int i = 0; i < 3; i++) step("err", '0, 1'($urandom), 1'b1);
    dead = 1'b1;
  endtask
  // n stalled cycles, then the completing cycle; 15 stalls mean a timeout trap instead
  task automatic wait_phase(input string tag, input ctl_t w, input ctl_t d, input int n, output bit to);
    to = 1'b0;
    for (int i = 0; i < n && i < 15; i++) step(tag, w, 1'b0, 1'b0);
    if (n >= 15) begin
      to = 1'b1;
      trapped();
    end else step(tag, d, 1'b1, 1'b0);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle", 64'(obs), 64'd0);
    check("idle_err", 64'(bus.err), 64'd0);
    check("idle_cnt", 64'(bus.retire_cnt), 64'd0);
    exp_cnt = '0;
    dead = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out", 64'(obs), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    release_rst();
  endtask
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fun, input int fw, input int mw, input bit ab);
    ctl_t e, w, d;
    bit to;
    bus.instr_op = op;
    bus.instr_fun = fun;
    w = '0;
    w.mrd = 1'b1;
    w.asb = 2'd1;
    d = w;
    d.pcw = 1'b1;
    d.irw = 1'b1;
    wait_phase("fetch", w, d, fw, to);
    if (to) return;
    e = '0;
    e.asb = 2'd3;
    step("decode", e, 1'($urandom), 1'b0);
    e = '0;
    if (op == 6'h00 && fun == 6'h08) begin
      e.pcw = 1'b1; e.psrc = 2'd3; e.ret = 1'b1;
      step("jr", e, 1'($urandom), 1'b0);
    end else if (op == 6'h00) begin
      e.asa = 1'b1; e.aop = 3'b010;
      step("exec", e, 1'($urandom), 1'b0);
      e = '0; e.rw = 1'b1; e.rdst = 2'd1; e.ret = 1'b1;
      step("rwb", e, 1'($urandom), 1'b0);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e.asa = 1'b1; e.asb = 2'd2;
      step("memadr", e, 1'($urandom), 1'b0);
      w = '0; w.iod = 1'b1;
      if (op == 6'h23) w.mrd = 1'b1; else w.mwr = 1'b1;
      d = w;
      d.ret = op == 6'h2B;
      if (ab) begin
        step("memwr", w, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_out", 64'(obs), 64'd0);
        check("abort_cnt", 64'(bus.retire_cnt), 64'd0);
        check("abort_err", 64'(bus.err), 64'd0);
        exp_cnt = '0;
        return;
      end
      wait_phase(op == 6'h23 ? "memrd" : "memwr", w, d, mw, to);
      if (!to && op == 6'h23) begin
        e = '0; e.rw = 1'b1; e.m2r = 2'd1; e.ret = 1'b1;
        step("memwb", e, 1'($urandom), 1'b0);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e.asa = 1'b1; e.aop = 3'b001; e.pcc = 1'b1; e.psrc = 2'd1; e.bne = op == 6'h05; e.ret = 1'b1;
      step("branch", e, 1'($urandom), 1'b0);
    end else if (op == 6'h08 || op == 6'h0A) begin
      e.asa = 1'b1; e.asb = 2'd2; e.aop = op == 6'h08 ? 3'b000 : 3'b011;
      step("immex", e, 1'($urandom), 1'b0);
      e = '0; e.rw = 1'b1; e.ret = 1'b1;
      step("iwb", e, 1'($urandom), 1'b0);
    end else if (op == 6'h02) begin
      e.pcw = 1'b1; e.psrc = 2'd2; e.ret = 1'b1;
      step("jump", e, 1'($urandom), 1'b0);
    end else if (op == 6'h03) begin
      e.pcw = 1'b1; e.psrc = 2'd2; e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2; e.ret = 1'b1;
      step("jal", e, 1'($urandom), 1'b0);
    end else trapped();
  endtask
  logic [5:0] legal [11] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h02, 6'h03};
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [5:0] op, fun;
    bit bad;
    bus.instr_op = '0;
    bus.instr_fun = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    check("rst_out", 64'(obs), 64'd0);
    check("rst_cnt", 64'(bus.retire_cnt), 64'd0);
    release_rst();
    do_instr(6'h00, 6'h20, 0, 0, 1'b0);
    do_instr(6'h23, 6'h00, 0, 3, 1'b0);
    do_instr(6'h04, 6'h00, 0, 0, 1'b0);
    do_instr(6'h05, 6'h00, 0, 0, 1'b0);
    do_instr(6'h03, 6'h00, 0, 0, 1'b0);
    do_instr(6'h00, 6'h08, 0, 0, 1'b0);
    do_instr(6'h3F, 6'h00, 0, 0, 1'b0);
    do_reset();
    do_instr(6'h00, 6'h20, 15, 0, 1'b0);
    do_reset();
    do_instr(6'h23, 6'h00, 1, 14, 1'b0);
    do_instr(6'h2B, 6'h00, 0, 15, 1'b0);
    do_reset();
    do_instr(6'h2B, 6'h00, 0, 5, 1'b1);
    release_rst();
    for (int i = 0; i < 16; i++) do_instr(legal[$urandom_range(10)], 6'h20, $urandom_range(2), $urandom_range(3), 1'b0);
    @(negedge clk);
    #1;
    check("wrap_cnt", 64'(bus.retire_cnt), 64'd0);
    do_reset();
    for (int i = 0; i < 120; i++) begin
      bad = $urandom_range(15) == 0;
      op = legal[$urandom_range(10)];
      if (bad) begin
        op = 6'($urandom);
        if (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h02, 6'h03}) op = 6'h3F;
      end
      fun = $urandom_range(5) == 0 ? 6'h08 : 6'($urandom);
      do_instr(op, fun, $urandom_range(24) == 0 ? 15 : $urandom_range(2),
               $urandom_range(19) == 0 ? 15 : $urandom_range(4), 1'b0);
      if (dead) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
